des_sbox_layer: RTL and testbench
=================================

// Module: des_sbox_layer
// PURPOSE
//  Full DES S-box substitution layer: accepts a 48-bit expanded/key-mixed word and returns the 32-bit
//  concatenation of S1..S8 outputs. Lookups are time-multiplexed: LANES boxes are evaluated per cycle.
//  Valid/ready handshakes on both sides. Sits between the key-mix XOR and the P permutation of the round.
// PARAMETERS
//  LANES  2  S-boxes evaluated per cycle; legal values 1, 2, 4, 8; anything else is a $error at elaboration.
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   in_data is valid
//  in_ready   out  1   block can accept in_data this cycle
//  in_data    in   48  box k (1..8) index = in_data[53-6k -: 6], so S1 = [47:42] and S8 = [5:0]
//  out_valid  out  1   out_data is valid and held stable until accepted
//  out_ready  in   1   downstream accepts out_data
//  out_data   out  32  box k nibble at [35-4k -: 4], so S1 = [31:28]; P-permuted if macro set
//  busy       out  1   high in SUB state
// BEHAVIOUR
//  - Lookup: row = {idx[5], idx[0]}, col = idx[4:1]. Values come from the standard DES S1..S8 tables.
//  - FSM states:
//    - IDLE: in_ready = 1. A transfer (in_valid & in_ready) captures in_data into in_reg, clears grp,
//      and moves to SUB.
//    - SUB: each cycle, boxes grp*LANES+1 .. grp*LANES+LANES are looked up and their nibbles written
//      into res_reg. grp increments; on grp == 8/LANES-1 the state moves to HOLD.
//    - HOLD: out_valid = 1 and out_data = res_reg (registered, stable).
//      - out_ready = 1: the result is consumed. If in_valid is also 1, the new word is captured and the
//        state goes directly to SUB (back-to-back; in_ready = out_ready in HOLD). Otherwise the state
//        returns to IDLE.
//      - out_ready = 0: hold indefinitely. in_ready = 0 and in_data is ignored.
//  - Latency: with accept at edge N, out_valid rises at edge N+8/LANES.
//    - LANES = 8: 1 cycle. LANES = 1: 8 cycles.
//    - Throughput is one word per 8/LANES cycles with out_ready held high.
//  - in_data changes after capture have no effect; in_reg is only loaded on a transfer.
//  - Reset values:
//    - state = IDLE, grp = 0, in_reg = 0, res_reg = 0.
//    - out_valid = 0, busy = 0, in_ready = 0 during reset.
//    - in_ready = 1 on the first cycle after reset.
//  - Reset mid-SUB or mid-HOLD: the in-flight word is discarded with no output, and the state returns to IDLE.
//  - grp width = $clog2(8/LANES), minimum 1 bit. The grp compare must not wrap for LANES = 8.
// CONFIGURATION
//  DES_SBOX_PERMUTE_EN
//    - defined: out_data = P(res_reg), using the standard DES 32-bit P table applied combinationally
//      from res_reg. Latency is unchanged.
//    - undefined: out_data = res_reg, the raw S-box concatenation.
// STRUCTURE
//  - des_pkg:
//    - SBOX constant [8][64] of 4-bit values, indexed [box][{row,col}].
//    - P_TABLE constant [32].
//    - FSM state typedef {IDLE, SUB, HOLD}.
//  - Sub-module des_sbox_lut: combinational (box_sel[2:0], idx[5:0]) -> val[3:0] from des_pkg::SBOX.
//    It is instantiated LANES times, and lane j selects box grp*LANES+j.
// TESTING  (macro undefined unless stated)
//  1. Zero input, LANES = 2: in_data = 48'h0 accepted.
//     -> out_valid exactly 4 cycles later, out_data = 32'hEFA72C4D.
//  2. Ones input, LANES = 8: in_data = 48'hFFFF_FFFF_FFFF accepted.
//     -> out_valid next cycle, out_data = 32'hD9CE3DCB.
//  3. Backpressure, LANES = 1: out_ready held 0 for 20 cycles.
//     -> out_valid stays 1, out_data stable, in_ready = 0.
//     -> Then out_ready = 1 with in_valid = 1: the new word is taken in the same cycle and busy = 1
//        on the next cycle.
//  4. Reset mid-SUB: rst asserted 2 cycles after accept (LANES = 1).
//     -> The next cycle has out_valid = 0, busy = 0, in_ready = 1, and no stale output ever appears.
//  5. DES_SBOX_PERMUTE_EN defined, in_data = 48'h0.
//     -> out_data = 32'hD8D8DBBC.
//  6. Streaming: random 1000 words for each LANES in {1, 2, 4, 8}, with random out_ready.
//     -> Compare against a package-table reference model. No drops or duplicates, and order is preserved.

Source files
------------

// File: rtl/des_pkg.sv
// DES S-box layer shared definitions: S1..S8 tables, P permutation table,
// FSM state type and the word types that travel through the layer.
// Consumers: des_sbox_lut (table lookup), des_sbox_layer (FSM, P output).
package des_pkg;

    localparam int unsigned NBOX    = 8;
    localparam int unsigned IN_W    = 48;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned NIB_W   = 4;

    // Box k (0-based) occupies element k; element 0 is the most significant
    typedef logic [0:NBOX-1][IDX_W-1:0] sbox_in_t;
    typedef logic [0:NBOX-1][NIB_W-1:0] sbox_out_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } sbox_state_e;

    // SBOX[box][{row,col}]; each 64-bit literal is one 16-entry row, S1 first
    localparam logic [0:NBOX-1][0:63][NIB_W-1:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Output bit i (1 = MSB) takes input bit P_TABLE[i-1] (1 = MSB)
    localparam int unsigned P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [OUT_W-1:0] p_permute(input logic [OUT_W-1:0] x);
        logic [OUT_W-1:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            y[5'(31 - i)] = x[5'(32 - P_TABLE[i])];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box lookup: box_sel picks S1..S8 (0..7), idx is the 6-bit box input.
// Ports: box_sel[2:0], idx[5:0] in; val[3:0] out (combinational).
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0]       box_sel,
    input  logic [IDX_W-1:0] idx,
    output logic [NIB_W-1:0] val
);

    // Outer bits form the row, inner four the column
    assign val = SBOX[box_sel][{idx[5], idx[0], idx[4:1]}];

endmodule

// File: rtl/des_sbox_layer.sv
// DES S-box substitution layer, LANES boxes evaluated per cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data[47:0] input
// handshake; out_valid/out_ready/out_data[31:0] output handshake; busy (SUB state).
// Build option: DES_SBOX_PERMUTE_EN applies the DES P permutation to out_data.
module des_sbox_layer
    import des_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    localparam int unsigned NGRP = NBOX / LANES;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_layer: LANES must be 1, 2, 4 or 8, got %0d", LANES);
    end

    sbox_state_e      state_q;
    sbox_state_e      state_d;
    logic [GW-1:0]    grp_q;
    sbox_in_t         in_q;
    sbox_out_t        res_q;
    sbox_out_t        res_d;
    logic             take;
    logic             sub_en;
    logic [2:0]       lane_box [LANES];
    logic [NIB_W-1:0] lane_val [LANES];

    // Next state and handshake decode
    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        sub_en   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    take    = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                sub_en = 1'b1;
                if (grp_q == GRP_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A new word may enter in the same cycle the result leaves
                in_ready = out_ready & ~rst;
                if (out_ready) begin
                    if (in_valid) begin
                        take    = 1'b1;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == HOLD);
            busy      <= (state_d == SUB);
        end
    end

    // Input capture and group counter
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= '0;
            grp_q <= '0;
        end else if (take) begin
            in_q  <= in_data;
            grp_q <= '0;
        end else if (sub_en) begin
            grp_q <= (grp_q == GRP_LAST) ? '0 : grp_q + GW'(1);
        end
    end

    // Lane j handles box grp*LANES + j of the current word
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_box[j] = 3'(32'(grp_q) * LANES + 32'(j));
        des_sbox_lut u_lut (
            .box_sel (lane_box[j]),
            .idx     (in_q[lane_box[j]]),
            .val     (lane_val[j])
        );
    end

    // Merge this group's nibbles into the result word
    always_comb begin
        res_d = res_q;
        for (int j = 0; j < LANES; j++) begin
            res_d[lane_box[j]] = lane_val[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (sub_en) begin
            res_q <= res_d;
        end
    end

`ifdef DES_SBOX_PERMUTE_EN
    assign out_data = p_permute(res_q);
`else
    assign out_data = res_q;
`endif

endmodule

// File: tb/tb_des_sbox_layer.sv
// Self-checking bench for des_sbox_layer: one instance per LANES value
// (index 0..3 -> LANES 1, 2, 4, 8), directed vectors plus streaming.
module tb_des_sbox_layer;

    localparam int NW = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv  [4];
    logic        ir  [4];
    logic [47:0] id  [4];
    logic        ov  [4];
    logic        orr [4];
    logic [31:0] od  [4];
    logic        bz  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_sbox_layer #(.LANES(1)) u_l1 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .busy(bz[0]));
    des_sbox_layer #(.LANES(2)) u_l2 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .busy(bz[1]));
    des_sbox_layer #(.LANES(4)) u_l4 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .busy(bz[2]));
    des_sbox_layer #(.LANES(8)) u_l8 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(id[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .busy(bz[3]));

    // Reference S-box tables, one 64-bit literal per row, S1 first
    localparam logic [0:7][0:63][3:0] TB_SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [31:0] ref_sub(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  ix;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            ix = d[47 - 6*k -: 6];
            r[31 - 4*k -: 4] = TB_SBOX[3'(k)][{ix[5], ix[0], ix[4:1]}];
        end
        return r;
    endfunction

`ifdef DES_SBOX_PERMUTE_EN
    localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    function automatic logic [31:0] tb_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31 - i] = x[32 - TB_P[i]];
        return y;
    endfunction
    function automatic logic [31:0] finish_out(input logic [31:0] raw);
        return tb_p(raw);
    endfunction
`else
    function automatic logic [31:0] finish_out(input logic [31:0] raw);
        return raw;
    endfunction
`endif

    function automatic logic [31:0] ref_out(input logic [47:0] d);
        return finish_out(ref_sub(d));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Wait for out_valid after an accept edge; returns edges counted
    task automatic wait_out(input int l, output int lat);
        lat = 0;
        while (!ov[l] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int l, input logic [47:0] d, input logic [31:0] exp, input string name);
        int lat;
        @(negedge clk);
        id[l]  = d;
        iv[l]  = 1'b1;
        orr[l] = 1'b0;
        #1 chk1($sformatf("%s L%0d in_ready", name, 1 << l), ir[l], 1'b1);
        @(posedge clk);
        #1;
        iv[l] = 1'b0;
        id[l] = ~d;
        chk1($sformatf("%s L%0d busy", name, 1 << l), bz[l], 1'b1);
        wait_out(l, lat);
        chk($sformatf("%s L%0d latency", name, 1 << l), 32'(lat), 32'(8 >> l));
        chk($sformatf("%s L%0d data", name, 1 << l), od[l], exp);
        @(negedge clk);
        orr[l] = 1'b1;
        @(posedge clk);
        #1;
        orr[l] = 1'b0;
        chk1($sformatf("%s L%0d released", name, 1 << l), ov[l], 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [47:0] din;
        logic [31:0] raw;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] q [4][$];
    int          sent [4];
    int          got  [4];
    int          cyc;
    int          lat;
    int          bad_v, bad_d, bad_r;
    logic [31:0] hold;
    logic [31:0] exp;

    initial begin
        vecs[0] = '{"zero",  48'h0000_0000_0000, 32'hEFA72C4D};
        vecs[1] = '{"ones",  48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB};
        vecs[2] = '{"row1",  48'h0410_4104_1041, 32'h03DDEAD1};
        vecs[3] = '{"row2",  48'h8208_2082_0820, 32'h40DA4917};
        vecs[4] = '{"col15", 48'h79E7_9E79_E79E, 32'h7A8F9B17};

        rst = 1'b1;
        for (int l = 0; l < 4; l++) begin
            iv[l] = 1'b0; id[l] = '0; orr[l] = 1'b0; sent[l] = 0; got[l] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            chk1($sformatf("reset L%0d in_ready", 1 << l), ir[l], 1'b0);
            chk1($sformatf("reset L%0d out_valid", 1 << l), ov[l], 1'b0);
            chk1($sformatf("reset L%0d busy", 1 << l), bz[l], 1'b0);
            chk($sformatf("reset L%0d out_data", 1 << l), od[l], 32'h0);
        end
        rst = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) chk1($sformatf("post-reset L%0d in_ready", 1 << l), ir[l], 1'b1);

        // Directed vectors on every lane count
        for (int v = 0; v < 5; v++)
            for (int l = 0; l < 4; l++)
                run_vec(l, vecs[v].din, finish_out(vecs[v].raw), vecs[v].name);

`ifdef DES_SBOX_PERMUTE_EN
        run_vec(1, 48'h0, 32'hD8D8DBBC, "perm-zero");
`endif

        // Backpressure on LANES=1: held result, blocked input, then back-to-back take
        @(negedge clk);
        id[0] = 48'h0; iv[0] = 1'b1; orr[0] = 1'b0;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, lat);
        chk("bp latency", 32'(lat), 32'd8);
        hold = od[0];
        chk("bp data", hold, finish_out(32'hEFA72C4D));
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            iv[0] = 1'b1;
            id[0] = {16'($urandom), $urandom};
            #1;
            if (!ov[0]) bad_v++;
            if (od[0] !== hold) bad_d++;
            if (ir[0]) bad_r++;
        end
        chk("bp out_valid drops", 32'(bad_v), 32'd0);
        chk("bp out_data changes", 32'(bad_d), 32'd0);
        chk("bp in_ready highs", 32'(bad_r), 32'd0);
        @(negedge clk);
        id[0] = 48'hFFFF_FFFF_FFFF; iv[0] = 1'b1; orr[0] = 1'b1;
        #1 chk1("b2b in_ready", ir[0], 1'b1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0; orr[0] = 1'b0;
        chk1("b2b busy", bz[0], 1'b1);
        chk1("b2b out_valid", ov[0], 1'b0);
        wait_out(0, lat);
        chk("b2b latency", 32'(lat), 32'd8);
        chk("b2b data", od[0], finish_out(32'hD9CE3DCB));
        @(negedge clk);
        orr[0] = 1'b1;
        @(posedge clk);
        #1 orr[0] = 1'b0;

        // Reset two cycles after accept on LANES=1
        @(negedge clk);
        id[0] = 48'h1234_5678_9ABC; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("midsub rst in_ready", ir[0], 1'b0);
        chk1("midsub rst out_valid", ov[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("midsub in_ready", ir[0], 1'b1);
        chk1("midsub out_valid", ov[0], 1'b0);
        chk1("midsub busy", bz[0], 1'b0);
        bad_v = 0;
        orr[0] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (ov[0]) bad_v++;
        end
        orr[0] = 1'b0;
        chk("midsub stale outputs", 32'(bad_v), 32'd0);

        // Streaming on all lane counts with random valid/ready
        cyc = 0;
        while ((got[0] < NW || got[1] < NW || got[2] < NW || got[3] < NW) && cyc < 40000) begin
            @(negedge clk);
            for (int l = 0; l < 4; l++) begin
                orr[l] = ($urandom_range(0, 3) != 0);
                if (sent[l] < NW && $urandom_range(0, 4) != 0) begin
                    iv[l] = 1'b1;
                    id[l] = {16'($urandom), $urandom};
                end else begin
                    iv[l] = 1'b0;
                end
            end
            #1;
            for (int l = 0; l < 4; l++) begin
                if (ov[l] && orr[l]) begin
                    if (q[l].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream L%0d extra output: got %h expected none", 1 << l, od[l]);
                    end else begin
                        exp = q[l].pop_front();
                        chk($sformatf("stream L%0d word %0d", 1 << l, got[l]), od[l], exp);
                        got[l]++;
                    end
                end
                if (iv[l] && ir[l]) begin
                    q[l].push_back(ref_out(id[l]));
                    sent[l]++;
                end
            end
            cyc++;
        end
        for (int l = 0; l < 4; l++) begin
            iv[l] = 1'b0;
            orr[l] = 1'b1;
        end
        bad_v = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int l = 0; l < 4; l++) if (ov[l]) bad_v++;
        end
        chk("stream trailing outputs", 32'(bad_v), 32'd0);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("stream L%0d received", 1 << l), 32'(got[l]), 32'(NW));
            chk($sformatf("stream L%0d pending", 1 << l), 32'(q[l].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
